latch_write_ctrl: RTL and testbench
===================================

# latch_write_ctrl

Sequenced write controller that sits directly upstream of a bank of `WIDTH` gated D latches built from NOR gates. It accepts a write request, presents data on the latch `D` inputs, and asserts the latch enable `En` only after a setup window. It holds `D` stable through a hold window after `En` falls, then reads back the latch `Q` outputs through a two-flop synchronizer and reports pass/fail. Its purpose is to exercise the asynchronous latch bank safely from the synchronous Mojo fabric.

## Interface
Parameters:
- `WIDTH`, 8, number of latch bits driven and read back
- `SETUP_CYC`, 2, cycles `lat_D` is stable before `lat_En` rises (≥1)
- `PULSE_CYC`, 4, cycles `lat_En` is high (≥1)
- `HOLD_CYC`, 2, cycles `lat_D` is held after `lat_En` falls (≥1)

Ports:
- `clk`  in  1  single system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `req`  in  1  write request; a write is accepted on an edge where `req && ready`
- `wdata`  in  WIDTH  write data, sampled only on acceptance
- `ready`  out  1  controller idle, able to accept a request
- `lat_D`  out  WIDTH  to the latch `D` inputs
- `lat_En`  out  1  to the latch `En` inputs
- `lat_Q`  in  WIDTH  from the latch `Q` outputs (asynchronous, synchronized internally)
- `done`  out  1  one-cycle pulse at the end of each write
- `err`  out  1  valid with `done`: readback ≠ written data
- `rdata`  out  WIDTH  synchronized readback, valid with `done`, held until the next `done`

## Operation
- FSM states: IDLE → SETUP → PULSE → HOLD → SYNC → CHECK → IDLE.
- IDLE:
  - `ready`=1 and `lat_En`=0.
  - On acceptance: `lat_D`←`wdata`, load the counter, go to SETUP.
- SETUP: `SETUP_CYC` cycles, `lat_En`=0.
- PULSE: `PULSE_CYC` cycles, `lat_En`=1.
- HOLD: `HOLD_CYC` cycles, `lat_En`=0.
- SYNC: 2 cycles to flush the `lat_Q` synchronizer.
- CHECK: 1 cycle.
  - Registers `rdata`←sync(`lat_Q`), `err`←(sync(`lat_Q`)≠`lat_D`), `done`←1.
  - Next state IDLE.
- `lat_D` changes only on acceptance. It is constant from acceptance until the next acceptance, so it is also held through HOLD, SYNC and CHECK.
- `lat_En` is a direct register output (no combinational decode), so it is glitch-free.
- `req` while `ready`=0 is ignored; requests are not queued.
- `err` and `rdata` update only in the `done` cycle; `err` is not sticky.
- Counter width: `$clog2` of the largest of `SETUP_CYC`, `PULSE_CYC`, `HOLD_CYC`, 2, plus 1. It loads `N-1` on state entry and advances state at 0.

## Timing
- Reset values:
  - `ready`=1; `lat_En`=0.
  - `lat_D`=0, `rdata`=0, `done`=0, `err`=0.
  - Synchronizer flops 0; state IDLE.
- Cycle numbering: acceptance at edge E0; "cycle k" is the cycle following edge Ek.
  - `lat_D` is valid from cycle 0.
  - `lat_En`=1 in cycles `SETUP_CYC` … `SETUP_CYC+PULSE_CYC-1`.
  - `done`=1 and `ready`=1 in cycle `L = SETUP_CYC+PULSE_CYC+HOLD_CYC+3`. With default parameters L = 11.
- Back-to-back writes: a request in cycle L is accepted at edge E(L+1) (throughput L+1 cycles). The outgoing `done` still reports the previous write.
- Reset mid-operation:
  - Next cycle: state IDLE, `lat_En`=0, `lat_D`=0, no `done`.
  - The latch retains whatever it captured; no recovery write is issued.
- Simultaneous `rst` and `req`: reset wins and the request is dropped.

## Structure
- Shared package `latch_pkg`:
  - State encoding constants IDLE, SETUP, PULSE, HOLD, SYNC, CHECK (3-bit).
  - Default timing constants DEF_SETUP_CYC, DEF_PULSE_CYC, DEF_HOLD_CYC.
- One sub-module: `sync2`, a parameterized `WIDTH`-bit two-flop synchronizer with synchronous active-high reset to 0. It is instantiated on `lat_Q`.
- FSM, counter and output registers live in `latch_write_ctrl`.

## Test plan
The bench connects a behavioural model of a `WIDTH`-bit NOR-gate D latch bank (`Q` follows `D` while `En`=1, holds otherwise) and uses default parameters unless stated.
- Reset: `rst`=1 for 3 cycles → `ready`=1; `lat_En`, `lat_D`, `done`, `err`, `rdata` all 0.
- Single write: `wdata`=0xA5 accepted at E0 → `lat_D`=0xA5 from cycle 0; `lat_En`=1 exactly in cycles 2–5; `done` pulse in cycle 11 with `rdata`=0xA5, `err`=0.
- Faulty latch: bit 0 of the model stuck at 0, write 0x01 → `done` in cycle 11, `rdata`=0x00, `err`=1.
- Busy/back-to-back:
  - First write 0x11 at E0; `req` held high with `wdata`=0x3C during busy → ignored.
  - Request in cycle 11 accepted at E12; `lat_D`=0x3C from cycle 12.
  - Second `done` in cycle 23 with `rdata`=0x3C.
- Reset in cycle 3 (during PULSE) → cycle 4 has `lat_En`=0, `ready`=1, `lat_D`=0; no `done` ever follows.
- Minimum timing (`SETUP_CYC`=`PULSE_CYC`=`HOLD_CYC`=1): write 0xFF → `lat_En`=1 only in cycle 1, `done` in cycle 6, `err`=0.

Source files
------------

// File: rtl/latch_pkg.sv
// rtl/latch_pkg.sv - shared state encoding and timing defaults for the latch write controller
package latch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        SYNC  = 3'd4,
        CHECK = 3'd5
    } state_t;

    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_PULSE_CYC = 4;
    localparam int DEF_HOLD_CYC  = 2;

    // Two flop stages must settle before the readback is trusted
    localparam int SYNC_CYC = 2;

    // Largest of four phase lengths; sizes the shared phase counter
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous multi-bit input
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give the first stage a full cycle to resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/latch_write_ctrl.sv
// rtl/latch_write_ctrl.sv - sequenced setup/pulse/hold write into an async latch bank with readback check
module latch_write_ctrl
    import latch_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] wdata,
    output logic             ready,
    output logic [WIDTH-1:0] lat_D,
    output logic             lat_En,
    input  logic [WIDTH-1:0] lat_Q,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] rdata
);

    localparam int CNT_W = $clog2(max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, SYNC_CYC)) + 1;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_load;
    logic             cnt_zero;
    logic [WIDTH-1:0] q_sync;

    assign cnt_zero = (cnt == '0);

    sync2 #(
        .WIDTH (WIDTH)
    ) u_q_sync (
        .clk (clk),
        .rst (rst),
        .d   (lat_Q),
        .q   (q_sync)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: each timed phase ends when its counter reaches zero
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req)      next_state = SETUP;
            SETUP:   if (cnt_zero) next_state = PULSE;
            PULSE:   if (cnt_zero) next_state = HOLD;
            HOLD:    if (cnt_zero) next_state = SYNC;
            SYNC:    if (cnt_zero) next_state = CHECK;
            CHECK:                 next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    // Phase length minus one, loaded as each phase is entered
    always_comb begin
        cnt_load = '0;
        case (next_state)
            SETUP:   cnt_load = CNT_W'(SETUP_CYC - 1);
            PULSE:   cnt_load = CNT_W'(PULSE_CYC - 1);
            HOLD:    cnt_load = CNT_W'(HOLD_CYC - 1);
            SYNC:    cnt_load = CNT_W'(SYNC_CYC - 1);
            default: cnt_load = '0;
        endcase
    end

    // Phase counter: reload on a state change, otherwise count down to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= cnt_load;
        end else if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Output decode: only ready is combinational; everything touching the latch is registered
    always_comb begin
        ready = (state == IDLE);
    end

    // Latch enable is registered from the next state so it can never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_En <= 1'b0;
        end else begin
            lat_En <= (next_state == PULSE);
        end
    end

    // Latch data is captured on acceptance and left untouched until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_D <= '0;
        end else if (ready && req) begin
            lat_D <= wdata;
        end
    end

    // Readback compare: result and data are published together with the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            done <= (state == CHECK);
            if (state == CHECK) begin
                rdata <= q_sync;
                err   <= (q_sync != lat_D);
            end
        end
    end

endmodule

// File: tb/tb_latch_write_ctrl.sv
// tb/tb_latch_write_ctrl.sv - self-checking bench for latch_write_ctrl with a behavioural latch bank
module tb_latch_write_ctrl;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int P  = 4;
    localparam int H  = 2;
    localparam int L  = S + P + H + 3;
    localparam int LM = 1 + 1 + 1 + 3;

    typedef struct packed {
        logic [W-1:0] rdata;
        logic         err;
    } exp_t;

    typedef struct {
        logic [W-1:0] wdata;
        logic [W-1:0] stuck;
        logic [W-1:0] exp_rdata;
        logic         exp_err;
        string        name;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [W-1:0] wdata;
    logic         ready;
    logic [W-1:0] lat_d;
    logic         lat_en;
    logic [W-1:0] lat_q;
    logic         done;
    logic         err;
    logic [W-1:0] rdata;
    logic [W-1:0] latch_q;
    logic [W-1:0] stuck;

    logic         req_m;
    logic [W-1:0] wdata_m;
    logic         ready_m;
    logic [W-1:0] lat_d_m;
    logic         lat_en_m;
    logic [W-1:0] lat_q_m;
    logic         done_m;
    logic         err_m;
    logic [W-1:0] rdata_m;
    logic [W-1:0] latch_q_m;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[4];

    always #5 clk = ~clk;

    latch_write_ctrl #(
        .WIDTH(W), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .ready(ready),
        .lat_D(lat_d), .lat_En(lat_en), .lat_Q(lat_q),
        .done(done), .err(err), .rdata(rdata)
    );

    latch_write_ctrl #(
        .WIDTH(W), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)
    ) dut_min (
        .clk(clk), .rst(rst), .req(req_m), .wdata(wdata_m), .ready(ready_m),
        .lat_D(lat_d_m), .lat_En(lat_en_m), .lat_Q(lat_q_m),
        .done(done_m), .err(err_m), .rdata(rdata_m)
    );

    // Behavioural NOR-gate D latch banks: transparent while En=1, hold otherwise
    always @(lat_d or lat_en) if (lat_en) latch_q = lat_d;
    always @(lat_d_m or lat_en_m) if (lat_en_m) latch_q_m = lat_d_m;
    assign lat_q   = latch_q & ~stuck;
    assign lat_q_m = latch_q_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse of the default instance must match the oldest pending write
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_rdata", 32'(rdata), 32'(mon_e.rdata));
                check("sb_err", 32'(err), 32'(mon_e.err));
            end
        end
    end

    task automatic run_write(input logic [W-1:0] data, input logic [W-1:0] exp_rd,
                             input logic exp_e, input string tag);
        int t;
        t = 0;
        while (!ready && t < 50) begin
            step();
            t++;
        end
        check({tag, "_ready_wait"}, 32'(ready), 32'd1);
        req   = 1'b1;
        wdata = data;
        sb.push_back({exp_rd, exp_e});
        step();
        req = 1'b0;
        for (int k = 0; k <= L; k++) begin
            if (k > 0) step();
            check({tag, "_lat_d"}, 32'(lat_d), 32'(data));
            check({tag, "_lat_en"}, 32'(lat_en), 32'(k >= S && k < S + P));
            check({tag, "_done"}, 32'(done), 32'(k == L));
            check({tag, "_ready"}, 32'(ready), 32'(k == L));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{wdata: 8'hA5, stuck: 8'h00, exp_rdata: 8'hA5, exp_err: 1'b0, name: "single_a5"};
        vecs[1] = '{wdata: 8'h01, stuck: 8'h01, exp_rdata: 8'h00, exp_err: 1'b1, name: "stuck_bit0"};
        vecs[2] = '{wdata: 8'hFF, stuck: 8'h80, exp_rdata: 8'h7F, exp_err: 1'b1, name: "stuck_bit7"};
        vecs[3] = '{wdata: 8'h5A, stuck: 8'h00, exp_rdata: 8'h5A, exp_err: 1'b0, name: "clean_5a"};

        rst = 1'b1; req = 1'b0; wdata = '0; stuck = '0;
        req_m = 1'b0; wdata_m = '0;

        // Reset state
        repeat (3) step();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_lat_en", 32'(lat_en), 32'd0);
        check("rst_lat_d", 32'(lat_d), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_m_lat_en", 32'(lat_en_m), 32'd0);
        check("rst_m_ready", 32'(ready_m), 32'd1);
        rst = 1'b0;
        step();

        // Table-driven writes, issued back to back as soon as ready returns
        for (int i = 0; i < 4; i++) begin
            stuck = vecs[i].stuck;
            run_write(vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].name);
        end
        step();
        step();
        check("table_sb_drained", 32'(sb.size()), 32'd0);
        stuck = '0;

        // Busy request ignored, then accepted immediately after done
        req = 1'b1; wdata = 8'h11;
        sb.push_back({8'h11, 1'b0});
        step();
        wdata = 8'h3C;
        check("b2b_first_lat_d_c0", 32'(lat_d), 32'h11);
        for (int k = 1; k <= L; k++) begin
            step();
            check("b2b_first_lat_d", 32'(lat_d), 32'h11);
            check("b2b_busy_ready", 32'(ready), 32'(k == L));
            check("b2b_first_done", 32'(done), 32'(k == L));
        end
        sb.push_back({8'h3C, 1'b0});
        step();
        req = 1'b0;
        check("b2b_second_lat_d", 32'(lat_d), 32'h3C);
        check("b2b_second_ready", 32'(ready), 32'd0);
        for (int k = L + 2; k <= 2 * L + 1; k++) begin
            step();
            check("b2b_second_done", 32'(done), 32'(k == 2 * L + 1));
        end
        step();
        check("b2b_sb_drained", 32'(sb.size()), 32'd0);

        // Reset during the enable pulse
        req = 1'b1; wdata = 8'h77;
        sb.push_back({8'h77, 1'b0});
        step();
        req = 1'b0;
        step(); step(); step();
        check("midrst_lat_en_c3", 32'(lat_en), 32'd1);
        rst = 1'b1;
        step();
        check("midrst_lat_en", 32'(lat_en), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_lat_d", 32'(lat_d), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        sb.delete();
        for (int k = 0; k < 20; k++) begin
            step();
            check("midrst_no_done", 32'(done), 32'd0);
        end

        // Reset and request together: reset wins, request dropped
        rst = 1'b1; req = 1'b1; wdata = 8'h99;
        step();
        check("rstreq_lat_d", 32'(lat_d), 32'd0);
        check("rstreq_ready", 32'(ready), 32'd1);
        rst = 1'b0; req = 1'b0;
        step();
        check("rstreq_lat_d_after", 32'(lat_d), 32'd0);
        check("rstreq_ready_after", 32'(ready), 32'd1);

        // Minimum timing instance
        req_m = 1'b1; wdata_m = 8'hFF;
        step();
        req_m = 1'b0;
        for (int k = 0; k <= LM; k++) begin
            if (k > 0) step();
            check("min_lat_en", 32'(lat_en_m), 32'(k == 1));
            check("min_done", 32'(done_m), 32'(k == LM));
            check("min_lat_d", 32'(lat_d_m), 32'hFF);
        end
        check("min_rdata", 32'(rdata_m), 32'hFF);
        check("min_err", 32'(err_m), 32'd0);
        check("min_ready", 32'(ready_m), 32'd1);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
